// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin through one full-subtractor cell, LSB first,
// with a start/busy/done handshake, parallel result and serial bit stream.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ser_bit,
    output logic             ser_valid
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             br, d, br_next, last, load;

    assign d         = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last      = cnt == CW'(WIDTH - 1);
    assign load      = state == IDLE && start;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign ser_valid = state == RUN;
    assign ser_bit   = ser_valid & d;

    always_comb begin
        state_next = state;
        if (ena)
            state_next = load                 ? RUN  :
                         (state == RUN && last) ? DONE :
                         (state == DONE)        ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    // result enters at the MSB so after WIDTH shifts bit 0 sits at res[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (ena) begin
            if (load) begin
                a_sh <= a_in;
                b_sh <= b_in;
                br   <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= br_next;
                cnt  <= cnt + 1'b1;
                res  <= {d, res[WIDTH-1:1]};
                if (last) begin
                    diff       <= {d, res[WIDTH-1:1]};
                    borrow_out <= br_next;
                end
            end
        end
    end
endmodule
